// File: rtl/ttt_pkg.sv
// Shared encodings, FSM state type, win-line table and cursor helper
// for the tic-tac-toe game-state controller.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_P1     = 2'b01;
    localparam logic [1:0] CELL_P2     = 2'b10;
    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    localparam logic [3:0] CENTER_CELL = 4'd4;
    localparam logic [3:0] NUM_CELLS   = 4'd9;
    localparam int         NUM_LINES   = 8;

    typedef enum logic [1:0] { PLAY, CHECK, OVER } state_e;
    typedef enum logic [1:0] { DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT } dir_e;

    // Cell-index triples, ordered to match the win_line bit positions.
    localparam logic [3:0] LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic logic [3:0] move_cursor(input logic [3:0] cur, input dir_e dir,
                                               input logic wrap);
        logic [1:0] row;
        logic [1:0] col;
        row = 2'(cur / 4'd3);
        col = 2'(cur % 4'd3);
        unique case (dir)
            DIR_UP:    row = (row == 2'd0) ? (wrap ? 2'd2 : 2'd0) : row - 2'd1;
            DIR_DOWN:  row = (row == 2'd2) ? (wrap ? 2'd0 : 2'd2) : row + 2'd1;
            DIR_LEFT:  col = (col == 2'd0) ? (wrap ? 2'd2 : 2'd0) : col - 2'd1;
            DIR_RIGHT: col = (col == 2'd2) ? (wrap ? 2'd0 : 2'd2) : col + 2'd1;
        endcase
        return {2'b00, row} * 4'd3 + {2'b00, col};
    endfunction

endpackage

// File: rtl/ttt_win_check.sv
// Combinational line detector: flags whether `player` owns a complete line
// and reports the lowest-numbered such line one-hot.
module ttt_win_check
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  player,
    output logic        win,
    output logic [7:0]  win_line
);

    always_comb begin
        // NOTE: outputs take a default before the loop so no path leaves them unassigned (no latch).
        win      = 1'b0;
        win_line = '0;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (!win
                && board[2*LINES[l][0] +: 2] == player
                && board[2*LINES[l][1] +: 2] == player
                && board[2*LINES[l][2] +: 2] == player) begin
                win         = 1'b1;
                win_line[l] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game-state controller: button edge detection, cursor, placement,
// turn alternation and win/draw resolution, all held in registers for the renderer.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int START_PLAYER = 1,
    parameter int WRAP_CURSOR  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    output logic [17:0] board,
    output logic [3:0]  cursor,
    output logic [1:0]  turn,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [7:0]  win_line,
    output logic        illegal
);

    localparam logic [1:0] START_TURN = (START_PLAYER == 2) ? CELL_P2 : CELL_P1;
    localparam logic       WRAP       = (WRAP_CURSOR != 0);

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_SEL   = 4;

    logic [4:0]  btn, prev_q, press;
    state_e      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [3:0]  cursor_q, cursor_d;
    logic [3:0]  move_count_q, move_count_d;
    logic [1:0]  turn_q, turn_d;
    logic [1:0]  winner_q, winner_d;
    logic [7:0]  win_line_q, win_line_d;
    logic        game_over_q, game_over_d;
    logic        illegal_q, illegal_d;
    logic        line_win;
    logic [7:0]  line_mask;

    assign btn   = {btn_sel, btn_up, btn_down, btn_left, btn_right};
    assign press = btn & ~prev_q;

    ttt_win_check u_win_check (
        .board    (board_q),
        .player   (turn_q),
        .win      (line_win),
        .win_line (line_mask)
    );

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        cursor_d     = cursor_q;
        move_count_d = move_count_q;
        turn_d       = turn_q;
        winner_d     = winner_q;
        win_line_d   = win_line_q;
        game_over_d  = game_over_q;
        illegal_d    = 1'b0;
        case (state_q)
            PLAY: begin
                // Fixed priority: sel > up > down > left > right; the rest are dropped.
                if (press[BTN_SEL]) begin
                    if (board_q[2*cursor_q +: 2] == CELL_EMPTY) begin
                        board_d[2*cursor_q +: 2] = turn_q;
                        move_count_d             = move_count_q + 4'd1;
                        state_d                  = CHECK;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else if (press[BTN_UP]) begin
                    cursor_d = move_cursor(cursor_q, DIR_UP, WRAP);
                end else if (press[BTN_DOWN]) begin
                    cursor_d = move_cursor(cursor_q, DIR_DOWN, WRAP);
                end else if (press[BTN_LEFT]) begin
                    cursor_d = move_cursor(cursor_q, DIR_LEFT, WRAP);
                end else if (press[BTN_RIGHT]) begin
                    cursor_d = move_cursor(cursor_q, DIR_RIGHT, WRAP);
                end
            end
            CHECK: begin
                if (line_win) begin
                    winner_d    = turn_q;
                    win_line_d  = line_mask;
                    game_over_d = 1'b1;
                    state_d     = OVER;
                end else if (move_count_q == NUM_CELLS) begin
                    winner_d    = WINNER_DRAW;
                    win_line_d  = '0;
                    game_over_d = 1'b1;
                    state_d     = OVER;
                end else begin
                    turn_d  = (turn_q == CELL_P1) ? CELL_P2 : CELL_P1;
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (press[BTN_SEL]) begin
                    state_d      = PLAY;
                    board_d      = '0;
                    cursor_d     = CENTER_CELL;
                    move_count_d = '0;
                    turn_d       = START_TURN;
                    winner_d     = WINNER_NONE;
                    win_line_d   = '0;
                    game_over_d  = 1'b0;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q       <= '1;
            state_q      <= PLAY;
            board_q      <= '0;
            cursor_q     <= CENTER_CELL;
            move_count_q <= '0;
            turn_q       <= START_TURN;
            winner_q     <= WINNER_NONE;
            win_line_q   <= '0;
            game_over_q  <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            prev_q       <= btn;
            state_q      <= state_d;
            board_q      <= board_d;
            cursor_q     <= cursor_d;
            move_count_q <= move_count_d;
            turn_q       <= turn_d;
            winner_q     <= winner_d;
            win_line_q   <= win_line_d;
            game_over_q  <= game_over_d;
            illegal_q    <= illegal_d;
        end
    end

    assign board     = board_q;
    assign cursor    = cursor_q;
    assign turn      = turn_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign win_line  = win_line_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: three configurations share one button stream; a
// row/column reference model feeds a scoreboard, plus directed checks on key points.
module tb_ttt_game_ctrl;

    localparam int NCFG = 3;
    localparam int CFG_START [NCFG] = '{1, 1, 2};
    localparam bit CFG_WRAP  [NCFG] = '{1'b1, 1'b0, 1'b1};

    localparam int M_PLAY  = 0;
    localparam int M_CHECK = 1;
    localparam int M_OVER  = 2;

    localparam logic [4:0] B_NONE  = 5'b00000;
    localparam logic [4:0] B_SEL   = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    typedef struct packed {
        logic [17:0] board;
        logic [3:0]  cursor;
        logic [1:0]  turn;
        logic        game_over;
        logic [1:0]  winner;
        logic [7:0]  win_line;
        logic        illegal;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;

    logic [17:0] board_w     [NCFG];
    logic [3:0]  cursor_w    [NCFG];
    logic [1:0]  turn_w      [NCFG];
    logic        game_over_w [NCFG];
    logic [1:0]  winner_w    [NCFG];
    logic [7:0]  win_line_w  [NCFG];
    logic        illegal_w   [NCFG];

    int n_checks = 0;
    int n_errors = 0;
    int cur      = 4;

    // Reference model state, one copy per configuration.
    int         m_cell   [NCFG][3][3];
    int         m_row    [NCFG];
    int         m_col    [NCFG];
    int         m_turn   [NCFG];
    int         m_state  [NCFG];
    int         m_winner [NCFG];
    int         m_cnt    [NCFG];
    logic       m_over   [NCFG];
    logic       m_ill    [NCFG];
    logic [7:0] m_line   [NCFG];
    logic [4:0] m_prev   [NCFG];

    snap_t exp_q [$];

    always #5 clk = ~clk;

    ttt_game_ctrl #(.START_PLAYER(1), .WRAP_CURSOR(1)) u_dut_wrap (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel), .board(board_w[0]), .cursor(cursor_w[0]),
        .turn(turn_w[0]), .game_over(game_over_w[0]), .winner(winner_w[0]),
        .win_line(win_line_w[0]), .illegal(illegal_w[0])
    );

    ttt_game_ctrl #(.START_PLAYER(1), .WRAP_CURSOR(0)) u_dut_sat (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel), .board(board_w[1]), .cursor(cursor_w[1]),
        .turn(turn_w[1]), .game_over(game_over_w[1]), .winner(winner_w[1]),
        .win_line(win_line_w[1]), .illegal(illegal_w[1])
    );

    ttt_game_ctrl #(.START_PLAYER(2), .WRAP_CURSOR(1)) u_dut_p2 (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel), .board(board_w[2]), .cursor(cursor_w[2]),
        .turn(turn_w[2]), .game_over(game_over_w[2]), .winner(winner_w[2]),
        .win_line(win_line_w[2]), .illegal(illegal_w[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int step_back(input int v, input bit wrap);
        return (v == 0) ? (wrap ? 2 : 0) : v - 1;
    endfunction

    function automatic int step_fwd(input int v, input bit wrap);
        return (v == 2) ? (wrap ? 0 : 2) : v + 1;
    endfunction

    function automatic logic [7:0] full_lines(input int k, input int p);
        logic [7:0] m;
        m = '0;
        for (int r = 0; r < 3; r++)
            m[r] = (m_cell[k][r][0] == p) && (m_cell[k][r][1] == p) && (m_cell[k][r][2] == p);
        for (int c = 0; c < 3; c++)
            m[3+c] = (m_cell[k][0][c] == p) && (m_cell[k][1][c] == p) && (m_cell[k][2][c] == p);
        m[6] = (m_cell[k][0][0] == p) && (m_cell[k][1][1] == p) && (m_cell[k][2][2] == p);
        m[7] = (m_cell[k][0][2] == p) && (m_cell[k][1][1] == p) && (m_cell[k][2][0] == p);
        return m;
    endfunction

    task automatic model_clear(input int k);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                m_cell[k][r][c] = 0;
        m_row[k]    = 1;
        m_col[k]    = 1;
        m_turn[k]   = CFG_START[k];
        m_state[k]  = M_PLAY;
        m_over[k]   = 1'b0;
        m_winner[k] = 0;
        m_line[k]   = '0;
        m_ill[k]    = 1'b0;
        m_cnt[k]    = 0;
    endtask

    task automatic model_step(input int k, input logic r, input logic [4:0] b);
        logic [4:0] pr;
        logic [7:0] lines;
        if (r) begin
            model_clear(k);
            m_prev[k] = '1;
        end else begin
            pr        = b & ~m_prev[k];
            m_prev[k] = b;
            m_ill[k]  = 1'b0;
            case (m_state[k])
                M_PLAY: begin
                    if (pr[4]) begin
                        if (m_cell[k][m_row[k]][m_col[k]] == 0) begin
                            m_cell[k][m_row[k]][m_col[k]] = m_turn[k];
                            m_cnt[k]++;
                            m_state[k] = M_CHECK;
                        end else begin
                            m_ill[k] = 1'b1;
                        end
                    end else if (pr[3]) m_row[k] = step_back(m_row[k], CFG_WRAP[k]);
                    else if (pr[2])     m_row[k] = step_fwd(m_row[k], CFG_WRAP[k]);
                    else if (pr[1])     m_col[k] = step_back(m_col[k], CFG_WRAP[k]);
                    else if (pr[0])     m_col[k] = step_fwd(m_col[k], CFG_WRAP[k]);
                end
                M_CHECK: begin
                    lines = full_lines(k, m_turn[k]);
                    if (lines != 8'h00) begin
                        m_winner[k] = m_turn[k];
                        m_line[k]   = lines & (~lines + 8'd1);
                        m_over[k]   = 1'b1;
                        m_state[k]  = M_OVER;
                    end else if (m_cnt[k] == 9) begin
                        m_winner[k] = 3;
                        m_line[k]   = '0;
                        m_over[k]   = 1'b1;
                        m_state[k]  = M_OVER;
                    end else begin
                        m_turn[k]  = 3 - m_turn[k];
                        m_state[k] = M_PLAY;
                    end
                end
                default: if (pr[4]) model_clear(k);
            endcase
        end
    endtask

    function automatic snap_t model_snap(input int k);
        snap_t s;
        s.board = '0;
        for (int i = 0; i < 9; i++) s.board[2*i +: 2] = 2'(m_cell[k][i/3][i%3]);
        s.cursor    = 4'(m_row[k] * 3 + m_col[k]);
        s.turn      = 2'(m_turn[k]);
        s.game_over = m_over[k];
        s.winner    = 2'(m_winner[k]);
        s.win_line  = m_line[k];
        s.illegal   = m_ill[k];
        return s;
    endfunction

    function automatic snap_t dut_snap(input int k);
        snap_t s;
        s.board     = board_w[k];
        s.cursor    = cursor_w[k];
        s.turn      = turn_w[k];
        s.game_over = game_over_w[k];
        s.winner    = winner_w[k];
        s.win_line  = win_line_w[k];
        s.illegal   = illegal_w[k];
        return s;
    endfunction

    // One clock: drive inputs, push model expectations, sample #1 after the edge.
    task automatic step(input logic r, input logic [4:0] b);
        snap_t e;
        rst = r;
        {btn_sel, btn_up, btn_down, btn_left, btn_right} = b;
        for (int k = 0; k < NCFG; k++) begin
            model_step(k, r, b);
            exp_q.push_back(model_snap(k));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NCFG; k++) begin
            e = exp_q.pop_front();
            check($sformatf("cfg%0d_outputs", k), 64'(dut_snap(k)), 64'(e));
        end
    endtask

    task automatic tap(input logic [4:0] b);
        step(1'b0, b);
        step(1'b0, B_NONE);
    endtask

    task automatic do_reset();
        step(1'b1, B_NONE);
        step(1'b1, B_NONE);
        step(1'b0, B_NONE);
        cur = 4;
    endtask

    task automatic move_to(input int t);
        while (cur / 3 > t / 3) begin tap(B_UP);    cur -= 3; end
        while (cur / 3 < t / 3) begin tap(B_DOWN);  cur += 3; end
        while (cur % 3 > t % 3) begin tap(B_LEFT);  cur -= 1; end
        while (cur % 3 < t % 3) begin tap(B_RIGHT); cur += 1; end
    endtask

    task automatic place(input int t);
        move_to(t);
        tap(B_SEL);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with sel held through and after reset: no placement may result.
        for (int i = 0; i < 3; i++) step(1'b1, B_SEL);
        for (int i = 0; i < 3; i++) step(1'b0, B_SEL);
        check("rst_board",   64'(board_w[0]),     64'(0));
        check("rst_cursor",  64'(cursor_w[0]),    64'(4));
        check("rst_turn",    64'(turn_w[0]),      64'(1));
        check("rst_illegal", 64'(illegal_w[0]),   64'(0));
        check("rst_over",    64'(game_over_w[0]), 64'(0));
        check("rst_turn_p2", 64'(turn_w[2]),      64'(2));
        step(1'b0, B_NONE);

        // Cursor edges: wrap vs saturate.
        tap(B_UP);
        check("wrap_up1", 64'(cursor_w[0]), 64'(1));
        check("sat_up1",  64'(cursor_w[1]), 64'(1));
        tap(B_UP);
        check("wrap_up2", 64'(cursor_w[0]), 64'(7));
        check("sat_up2",  64'(cursor_w[1]), 64'(1));
        do_reset();
        tap(B_LEFT);
        check("wrap_left1", 64'(cursor_w[0]), 64'(3));
        check("sat_left1",  64'(cursor_w[1]), 64'(3));
        tap(B_LEFT);
        check("wrap_left2", 64'(cursor_w[0]), 64'(5));
        check("sat_left2",  64'(cursor_w[1]), 64'(3));
        do_reset();

        // Placement latency, then select on the occupied cell.
        step(1'b0, B_SEL);
        check("place_cell_n1", 64'(board_w[0][9:8]), 64'(1));
        check("place_turn_n1", 64'(turn_w[0]),       64'(1));
        step(1'b0, B_NONE);
        check("place_turn_n2", 64'(turn_w[0]), 64'(2));
        step(1'b0, B_SEL);
        check("illegal_pulse", 64'(illegal_w[0]), 64'(1));
        step(1'b0, B_NONE);
        check("illegal_clear", 64'(illegal_w[0]), 64'(0));
        check("illegal_board", 64'(board_w[0]),   64'(18'h00100));
        check("illegal_turn",  64'(turn_w[0]),    64'(2));

        // Held button yields one move only.
        step(1'b0, B_RIGHT);
        step(1'b0, B_RIGHT);
        step(1'b0, B_RIGHT);
        step(1'b0, B_NONE);
        check("held_right", 64'(cursor_w[0]), 64'(5));

        // Top-row win for the first player.
        do_reset();
        place(0); place(3); place(1); place(4); place(2);
        check("win_over",     64'(game_over_w[0]), 64'(1));
        check("win_winner",   64'(winner_w[0]),    64'(1));
        check("win_line",     64'(win_line_w[0]),  64'(8'h01));
        check("win_turn",     64'(turn_w[0]),      64'(1));
        check("win_board",    64'(board_w[0]),     64'(18'h00295));
        check("win_winner_p2", 64'(winner_w[2]),   64'(2));
        tap(B_UP); tap(B_LEFT); tap(B_DOWN);
        check("over_cursor", 64'(cursor_w[0]), 64'(2));
        check("over_board",  64'(board_w[0]),  64'(18'h00295));

        // Restart from OVER.
        tap(B_SEL);
        cur = 4;
        check("restart_board",   64'(board_w[0]),  64'(0));
        check("restart_cursor",  64'(cursor_w[0]), 64'(4));
        check("restart_turn",    64'(turn_w[0]),   64'(1));
        check("restart_winner",  64'(winner_w[0]), 64'(0));
        check("restart_turn_p2", 64'(turn_w[2]),   64'(2));

        // Draw on the ninth move.
        place(0); place(1); place(2); place(4); place(3);
        place(5); place(7); place(6); place(8);
        check("draw_over",   64'(game_over_w[0]), 64'(1));
        check("draw_winner", 64'(winner_w[0]),    64'(3));
        check("draw_line",   64'(win_line_w[0]),  64'(0));
        check("draw_board",  64'(board_w[0]),     64'(18'h16A59));
        tap(B_SEL);
        cur = 4;

        // Same-cycle presses: sel beats up; up beats left.
        step(1'b0, B_SEL | B_UP);
        check("prio_cell",   64'(board_w[0][9:8]), 64'(1));
        check("prio_cursor", 64'(cursor_w[0]),     64'(4));
        step(1'b0, B_NONE);
        tap(B_UP | B_LEFT);
        check("prio_move", 64'(cursor_w[0]), 64'(1));
        step(1'b0, B_NONE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
